// File: rtl/encode_stream_ctrl.sv
// Streaming ByteEncode_d sequencer: packs the low d bits of 256 coefficients
// LSB-first into a little-endian stream of 32*d bytes through a 20-bit accumulator.
module encode_stream_ctrl #(
    parameter int N_COEF = 256,
    parameter int D_MAX  = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  d_sel,
    input  logic        coef_valid,
    input  logic [15:0] coef_data,
    output logic        coef_ready,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    output logic        byte_last,
    input  logic        byte_ready,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int ACC_W = D_MAX + 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [3:0]        d_q;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [4:0]        acc_cnt_q, acc_cnt_d;
    logic [8:0]        coef_cnt_q, coef_cnt_d;
    logic [8:0]        byte_cnt_q, byte_cnt_d;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic [D_MAX-1:0]  coef_mask;
    logic [ACC_W-1:0]  coef_bits;
    logic [8:0]        last_idx;
    logic              run;
    logic              coef_hs;
    logic              byte_hs;
    logic              d_ok;
    logic              unused_coef_hi;

    // Mask keeps only the low d bits, so negative inputs truncate cleanly.
    genvar gi;
    generate
        for (gi = 0; gi < D_MAX; gi++) begin : g_mask
            assign coef_mask[gi] = (5'(gi) < {1'b0, d_q});
        end
    endgenerate

    assign unused_coef_hi = ^coef_data[15:D_MAX];

    assign coef_bits = ACC_W'(coef_data[D_MAX-1:0] & coef_mask);
    assign last_idx  = {d_q, 5'b00000} - 9'd1;
    assign d_ok      = (d_sel != 4'd0) && (d_sel <= 4'(D_MAX));
    assign run       = (state_q == S_RUN);

    // Accumulator either takes a coefficient or yields a byte; never both.
    assign coef_ready = run && (acc_cnt_q < 5'd8) && (coef_cnt_q < 9'(N_COEF));
    assign byte_valid = run && (acc_cnt_q >= 5'd8);
    assign byte_data  = acc_q[7:0];
    assign byte_last  = byte_valid && (byte_cnt_q == last_idx);

    assign coef_hs = coef_valid && coef_ready;
    assign byte_hs = byte_valid && byte_ready;

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

    always_comb begin
        acc_d      = acc_q;
        acc_cnt_d  = acc_cnt_q;
        coef_cnt_d = coef_cnt_q;
        byte_cnt_d = byte_cnt_q;
        if (coef_hs) begin
            acc_d      = acc_q | (coef_bits << acc_cnt_q);
            acc_cnt_d  = acc_cnt_q + {1'b0, d_q};
            coef_cnt_d = coef_cnt_q + 9'd1;
        end else if (byte_hs) begin
            acc_d      = acc_q >> 8;
            acc_cnt_d  = acc_cnt_q - 5'd8;
            byte_cnt_d = byte_cnt_q + 9'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            d_q        <= 4'd0;
            acc_q      <= '0;
            acc_cnt_q  <= 5'd0;
            coef_cnt_q <= 9'd0;
            byte_cnt_q <= 9'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (d_ok) begin
                            d_q        <= d_sel;
                            acc_q      <= '0;
                            acc_cnt_q  <= 5'd0;
                            coef_cnt_q <= 9'd0;
                            byte_cnt_q <= 9'd0;
                            busy_q     <= 1'b1;
                            state_q    <= S_RUN;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    acc_q      <= acc_d;
                    acc_cnt_q  <= acc_cnt_d;
                    coef_cnt_q <= coef_cnt_d;
                    byte_cnt_q <= byte_cnt_d;
                    // 256*d is a multiple of 8, so the accumulator is empty here.
                    if (byte_hs && byte_last) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
